// File: rtl/vram_cmd_writer_pkg.sv
// Shared definitions for the host-side VRAM write engine.
// Holds the opcode values, the parser state encoding and the text-layout
// helpers. The renderer uses the same layout: character cells come first,
// and the color bytes follow at a fixed offset.
package vram_cmd_writer_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_FILL     = 8'h03;
  localparam logic [7:0] OP_PUTC     = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WR_CNT,
    ST_WR_DATA,
    ST_FILL_CH,
    ST_FILL_COL,
    ST_FILL_RUN,
    ST_PUTC_CH,
    ST_PUTC_COL,
    ST_PUTC_W2
  } state_e;

  // Number of character cells on the screen.
  function automatic int text_area(input int cols, input int rows);
    return cols * rows;
  endfunction

  // The color plane starts immediately after the character plane.
  function automatic int color_offset(input int cols, input int rows);
    return text_area(cols, rows);
  endfunction

endpackage

// File: rtl/vram_fill_seq.sv
// Address/data generator for the screen-fill command.
// A start pulse issues the first write (char at address 0) and latches
// char/color. While run is high, one write is issued per cycle until all
// 2*AREA writes are out. After that, done is raised.
// The write outputs are combinational; the parent module registers them.
module vram_fill_seq #(
  parameter int ADDR_W = 15,
  parameter int AREA   = 2400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [7:0]        char_in,
  input  logic [7:0]        color_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done
);

  localparam int TOTAL = 2 * AREA;
  localparam int IW    = $clog2(TOTAL + 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    color_q, color_d;

  // Choose the next fill write and advance the index.
  always_comb begin
    idx_d   = idx_q;
    char_d  = char_q;
    color_d = color_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (start) begin
      char_d  = char_in;
      color_d = color_in;
      wr_en   = 1'b1;
      wr_data = char_in;
      idx_d   = IW'(1);
    end else if (run && idx_q != IW'(TOTAL)) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(idx_q);
      wr_data = (idx_q < IW'(AREA)) ? char_q : color_q;
      idx_d   = idx_q + 1'b1;
    end
  end

  assign done = run && (idx_q == IW'(TOTAL));

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      char_q  <= '0;
      color_q <= '0;
    end else begin
      idx_q   <= idx_d;
      char_q  <= char_d;
      color_q <= color_d;
    end
  end

endmodule

// File: rtl/vram_cmd_writer.sv
// Host-side VRAM write engine.
// Parses host bytes into the commands SET_ADDR, WRITE, FILL and PUTC, and
// drives the VRAM write port. Every output is registered: a byte accepted
// in cycle T produces its write in cycle T+1.
// Optional feature: when VRAM_CMD_TIMEOUT_EN is defined, the engine abandons
// a partial command after TIMEOUT_CYCLES idle cycles.
module vram_cmd_writer #(
  parameter int ADDR_W         = 15,
  parameter int TEXT_COLS      = 80,
  parameter int TEXT_ROWS      = 30,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] vram_wr_addr,
  output logic [7:0]        vram_wr_data,
  output logic              vram_wr_en,
  output logic              busy,
  output logic              cmd_error
);
  import vram_cmd_writer_pkg::*;

  localparam int AREA = text_area(TEXT_COLS, TEXT_ROWS);
  localparam logic [ADDR_W-1:0] COLOR_OFF = ADDR_W'(color_offset(TEXT_COLS, TEXT_ROWS));
  localparam logic [ADDR_W-1:0] AREA_A    = ADDR_W'(AREA);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(AREA - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [ADDR_W-9:0]   hi_q, hi_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          fill_ch_q, fill_ch_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                err_q, err_d;

  logic                accept;
  logic                fill_start;
  logic                fill_wr_en;
  logic [ADDR_W-1:0]   fill_addr;
  logic [7:0]          fill_data;
  logic                fill_done;
  logic                tmo_fire;
  logic [ADDR_W-1:0]   set_ptr;

  assign rx_ready     = !rst && (state_q != ST_FILL_RUN) && (state_q != ST_PUTC_W2);
  assign accept       = rx_valid && rx_ready;
  assign busy         = (state_q != ST_IDLE);
  assign set_ptr      = {hi_q, rx_data};
  assign vram_wr_en   = wr_en_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign cmd_error    = err_q;

  vram_fill_seq #(
    .ADDR_W (ADDR_W),
    .AREA   (AREA)
  ) u_fill_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (fill_start),
    .run      (state_q == ST_FILL_RUN),
    .char_in  (fill_ch_q),
    .color_in (rx_data),
    .wr_en    (fill_wr_en),
    .wr_addr  (fill_addr),
    .wr_data  (fill_data),
    .done     (fill_done)
  );

`ifdef VRAM_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Count idle cycles inside a command. The two states that run without
  // host input are exempt from the timeout.
  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (busy && !accept && state_q != ST_FILL_RUN && state_q != ST_PUTC_W2) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_fire = 1'b1;
      else                                     tmo_d    = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Command parser: next state, pointer/cursor updates and the next write.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    cursor_d   = cursor_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    fill_ch_d  = fill_ch_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    fill_start = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        case (rx_data)
          OP_SET_ADDR: state_d = ST_ADDR_HI;
          OP_WRITE:    state_d = ST_WR_CNT;
          OP_FILL:     state_d = ST_FILL_CH;
          OP_PUTC:     state_d = ST_PUTC_CH;
          default:     err_d   = 1'b1;
        endcase
      end
      ST_ADDR_HI: if (accept) begin
        hi_d    = rx_data[ADDR_W-9:0];
        state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (accept) begin
        ptr_d = set_ptr;
        if (set_ptr < AREA_A) cursor_d = set_ptr;
        state_d = ST_IDLE;
      end
      ST_WR_CNT: if (accept) begin
        cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = rx_data;
        ptr_d     = ptr_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == 9'd1) state_d = ST_IDLE;
      end
      ST_FILL_CH: if (accept) begin
        fill_ch_d = rx_data;
        state_d   = ST_FILL_COL;
      end
      ST_FILL_COL: if (accept) begin
        fill_start = 1'b1;
        state_d    = ST_FILL_RUN;
      end
      ST_FILL_RUN: if (fill_done) state_d = ST_IDLE;
      ST_PUTC_CH: if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cursor_q;
        wr_data_d = rx_data;
        state_d   = ST_PUTC_COL;
      end
      ST_PUTC_COL: if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cursor_q + COLOR_OFF;
        wr_data_d = rx_data;
        cursor_d  = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
        state_d   = ST_PUTC_W2;
      end
      ST_PUTC_W2: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (fill_wr_en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fill_addr;
      wr_data_d = fill_data;
    end
    if (tmo_fire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  // State and output registers. A reset during a command abandons it at once.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments, so every flop samples the
    // values from before the clock edge.
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cursor_q  <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      fill_ch_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cursor_q  <= cursor_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      fill_ch_q <= fill_ch_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/vram_cmd_writer.md
Name: vram_cmd_writer

Overview:
Host-side VRAM write engine; sits directly upstream of the VRAM that the text-mode renderer reads.
- Parses a byte stream from the host link (UART/SPI byte receiver) into commands.
- Drives the VRAM write port: set address, burst write, screen fill, put-character.
- Owns only the write port; the renderer's read port is untouched.

Parameters:
ADDR_W, 15, VRAM address width; pointer wraps at 2^ADDR_W.
TEXT_COLS, 80, characters per row.
TEXT_ROWS, 30, character rows.
TIMEOUT_CYCLES, 1000000, idle-byte timeout (used only with optional feature).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  host byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  block accepts byte; transfer when rx_valid && rx_ready.
vram_wr_addr  out  ADDR_W  VRAM write address.
vram_wr_data  out  8  VRAM write data.
vram_wr_en  out  1  one-cycle write strobe.
busy  out  1  high while a command is in progress (any state but IDLE).
cmd_error  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset: all outputs 0, address pointer 0, state IDLE. rx_ready = 0 while rst is high and 1 on the first cycle after release. Reset mid-command aborts immediately; VRAM keeps any partial writes.
- AREA = TEXT_COLS*TEXT_ROWS (2400 by default). Character cells occupy [0, AREA); color bytes occupy [AREA, 2*AREA).
- Outputs are registered: a byte accepted in cycle T produces its write (vram_wr_en=1) in cycle T+1.
- rx_ready = 0 only in FILL_RUN and PUTC_W2; 1 in all other states.
- Opcodes, decoded in IDLE:
  - 0x01 SET_ADDR: IDLE -> ADDR_HI -> ADDR_LO -> IDLE. Pointer = {hi[ADDR_W-9:0], lo}; unused high bits of hi are ignored.
  - 0x02 WRITE: IDLE -> WR_CNT -> WR_DATA. Count byte N (0 means 256). N data bytes are written at the pointer, which increments after each write and wraps from 2^ADDR_W-1 to 0. Returns to IDLE after the Nth byte.
  - 0x03 FILL: IDLE -> FILL_CH -> FILL_COL -> FILL_RUN.
    - Writes char to addresses 0..AREA-1, then color to AREA..2*AREA-1, one write per cycle: 2*AREA cycles in total.
    - Returns to IDLE the cycle after the last write. Pointer unchanged.
  - 0x04 PUTC: IDLE -> PUTC_CH -> PUTC_COL -> PUTC_W2 -> IDLE.
    - The char is written at the cursor in the cycle after PUTC_CH accepts it.
    - The color is written at cursor+AREA in PUTC_W2 (rx_ready=0 for that one cycle).
    - Cursor is then incremented; it wraps at AREA-1 -> 0. The cursor is a separate register, reset to 0; SET_ADDR loads the cursor with (pointer mod AREA) only when pointer < AREA.
  - Any other opcode: byte consumed, cmd_error pulses in the next cycle, state stays IDLE.
- Writes never overlap: at most one vram_wr_en per cycle. vram_wr_en is 0 in every cycle without a write.
- Bytes presented while rx_ready=0 are held by the source (standard valid/ready; no drop).

Optional Feature:
VRAM_CMD_TIMEOUT_EN:
- Defined: a counter clears on every accepted byte. If busy and TIMEOUT_CYCLES cycles pass with no byte accepted, the block returns to IDLE and cmd_error pulses once. FILL_RUN and PUTC_W2 are exempt from the timeout.
- Undefined: no counter; partial commands wait indefinitely.

Decomposition:
- Shared package: opcode constants (OP_SET_ADDR, OP_WRITE, OP_FILL, OP_PUTC), state enum encoding, and the AREA/COLOR_OFFSET derivation shared with the renderer's text-layout constants.
- One natural sub-module: vram_fill_seq. Counter/address generator for FILL_RUN with start/done handshake, inputs char/color/AREA.

Test Plan:
- Reset release: in the cycle after rst drops, rx_ready=1, busy=0, vram_wr_en=0. Then send 01 12 34, 02 03 AA BB CC -> writes AA@0x1234, BB@0x1235, CC@0x1236, each one cycle after its byte is accepted.
- Wrap: 01 7F FF, 02 02 11 22 -> 11@0x7FFF, 22@0x0000.
- FILL: 03 41 1F -> exactly 4800 consecutive writes: 0x41 at 0..2399, then 0x1F at 2400..4799. rx_ready=0 throughout, busy falls after the last write, then a new opcode is accepted.
- PUTC: 01 00 4F, 04 48 07, 04 49 07 (cursor 79) -> 48@79, 07@2479, 49@80, 07@2480. Cursor at 2399 followed by PUTC wraps the cursor to 0.
- Error/reset: byte 0x7E -> cmd_error high for exactly 1 cycle, no write. Asserting rst mid-FILL at write 100 -> no writes after reset, state IDLE.
- VRAM_CMD_TIMEOUT_EN: send 02 05 11 then stall TIMEOUT_CYCLES -> cmd_error pulse, busy=0. The next byte 01 is parsed as an opcode.
